// File: rtl/approx_adder_pkg.sv
// Shared types and default sizing for the approximate adder pipeline.
package approx_adder_pkg;

  typedef enum logic [1:0] {
    AM_EXACT,
    AM_OR,
    AM_TRUNC,
    AM_DUP
  } approx_mode_e;

  localparam int unsigned W_DEF     = 8;
  localparam int unsigned ACC_W_DEF = 32;

endpackage

// File: rtl/approx_adder_core.sv
// Combinational approximate adder: low keff bits approximated per mode,
// upper bits [W-1:keff] always added exactly with a mode-dependent carry-in.
module approx_adder_core
  import approx_adder_pkg::*;
#(
  parameter int unsigned W  = W_DEF,
  parameter int unsigned KW = $clog2(W + 1)
) (
  input  logic [W-1:0]  a_i,
  input  logic [W-1:0]  b_i,
  input  approx_mode_e  mode_i,
  input  logic [KW-1:0] keff_i,
  output logic [W:0]    sum_o
);

  logic [W:0] a_x;
  logic [W:0] b_x;
  logic [W:0] mask;
  logic [W:0] msb_l;
  logic [W:0] exact;
  logic [W:0] upper;
  logic       cin_or;
  logic       dup_bit;

  // Masked upper add with the carry injected at bit keff; keff=0 gives an empty mask, so every mode is exact
  always_comb begin
    a_x     = {1'b0, a_i};
    b_x     = {1'b0, b_i};
    mask    = ((W + 1)'(1) << keff_i) - (W + 1)'(1);
    msb_l   = mask & ~(mask >> 1);
    exact   = a_x + b_x;
    upper   = (a_x & ~mask) + (b_x & ~mask);
    cin_or  = |(a_x & b_x & msb_l);
    dup_bit = |(exact & msb_l);
    case (mode_i)
      AM_OR:    sum_o = (upper + ((W + 1)'(cin_or) << keff_i)) | ((a_x | b_x) & mask);
      AM_TRUNC: sum_o = upper;
      AM_DUP:   sum_o = (exact & ~mask) | (dup_bit ? mask : '0);
      default:  sum_o = exact;
    endcase
  end

endmodule

// File: rtl/approx_adder_pipe.sv
// Two-stage valid/ready approximate adder pipeline.
// Optional error monitor enabled by defining APPROX_ADDER_ERR_MON_EN.
module approx_adder_pipe
  import approx_adder_pkg::*;
#(
  parameter int unsigned W     = W_DEF,
  parameter int unsigned ACC_W = ACC_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [W-1:0]             in_a,
  input  logic [W-1:0]             in_b,
  input  logic [1:0]               cfg_mode,
  input  logic [$clog2(W+1)-1:0]   cfg_k,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [W:0]               out_sum,
  input  logic                     stat_clr,
  output logic [ACC_W-1:0]         err_count,
  output logic [ACC_W-1:0]         err_sum,
  output logic [W:0]               err_max
);

  localparam int unsigned KW = $clog2(W + 1);

  logic              s1_valid_q;
  logic [W-1:0]      s1_a_q;
  logic [W-1:0]      s1_b_q;
  approx_mode_e      s1_mode_q;
  logic [KW-1:0]     s1_keff_q;
  logic              s2_valid_q;
  logic [W:0]        s2_sum_q;

  logic              adv1;
  logic              adv2;
  logic [KW-1:0]     keff_d;
  logic [W:0]        approx_sum;

  // Stage advance and config clamp; in_ready depends combinationally on out_ready
  always_comb begin
    adv2   = ~s2_valid_q | out_ready;
    adv1   = ~s1_valid_q | adv2;
    keff_d = (cfg_k > KW'(W)) ? KW'(W) : cfg_k;
  end

  assign in_ready  = adv1;
  assign out_valid = s2_valid_q;
  assign out_sum   = s2_sum_q;

  approx_adder_core #(.W(W)) u_core (
    .a_i    (s1_a_q),
    .b_i    (s1_b_q),
    .mode_i (s1_mode_q),
    .keff_i (s1_keff_q),
    .sum_o  (approx_sum)
  );

  // Pipeline registers: S1 captures the beat with its config, S2 the approximate sum
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_mode_q  <= AM_EXACT;
      s1_keff_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_sum_q   <= '0;
    end else begin
      if (adv1) begin
        s1_valid_q <= in_valid;
        if (in_valid) begin
          s1_a_q    <= in_a;
          s1_b_q    <= in_b;
          s1_mode_q <= approx_mode_e'(cfg_mode);
          s1_keff_q <= keff_d;
        end
      end
      if (adv2) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) s2_sum_q <= approx_sum;
      end
    end
  end

`ifdef APPROX_ADDER_ERR_MON_EN
  logic [W:0]       exact_sum;
  logic [W:0]       s2_exact_q;
  logic [W:0]       err_abs;
  logic [ACC_W:0]   acc_wide;
  logic [ACC_W-1:0] cnt_q;
  logic [ACC_W-1:0] acc_q;
  logic [W:0]       max_q;

  approx_adder_core #(.W(W)) u_ref (
    .a_i    (s1_a_q),
    .b_i    (s1_b_q),
    .mode_i (AM_EXACT),
    .keff_i (s1_keff_q),
    .sum_o  (exact_sum)
  );

  // Exact sum shadows the S2 result register
  always_ff @(posedge clk) begin
    if (rst)                     s2_exact_q <= '0;
    else if (adv2 && s1_valid_q) s2_exact_q <= exact_sum;
  end

  // Absolute error and widened accumulator sum for saturation detect
  always_comb begin
    err_abs  = (s2_sum_q > s2_exact_q) ? (s2_sum_q - s2_exact_q) : (s2_exact_q - s2_sum_q);
    acc_wide = {1'b0, acc_q} + (ACC_W + 1)'(err_abs);
  end

  // Statistics on result transfer; a coincident clear takes priority
  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      cnt_q <= '0;
      acc_q <= '0;
      max_q <= '0;
    end else if (s2_valid_q && out_ready) begin
      if (err_abs != '0 && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
      acc_q <= acc_wide[ACC_W] ? '1 : acc_wide[ACC_W-1:0];
      if (err_abs > max_q) max_q <= err_abs;
    end
  end

  assign err_count = cnt_q;
  assign err_sum   = acc_q;
  assign err_max   = max_q;
`else
  logic unused_stat_clr;
  assign unused_stat_clr = stat_clr;
  assign err_count       = '0;
  assign err_sum         = '0;
  assign err_max         = '0;
`endif

endmodule
